l1cache_assoc: RTL
==================

Name: l1cache_assoc

Overview:
Parametrised set-associative, write-back, write-allocate L1 data cache between the CPU memory stage and the MMU line interface.
- Generalises the direct-mapped l1cache to configurable ways, sets and line width.
- Adds per-set replacement state (LRU/tree-PLRU) and dirty-victim writeback selection.
- CPU side: word/half/byte access with combinational hit path. MMU side: whole-line read/write handshake.

Parameters:
WAYS, 2, associativity; legal values 1, 2 or 4
SETS, 64, sets per way; power of two, at least 2
LINE_BITS, 256, line width in bits; power of two, 64..512

Ports:
sys_clk  input  1  clock, all state updates on posedge
rst_n  input  1  asynchronous active-low reset
l1_read  input  1  read request, held stable while stall=1
l1_write  input  1  write request, held stable while stall=1
l1_addr  input  32  byte address
l1_write_type  input  2  00 word, 01 half, 10 byte, 11 treated as word
l1_write_data  input  32  write data, right-aligned for half/byte
l1_data_o  output  32  aligned word containing l1_addr
stall  output  1  CPU must hold request
l1_mmu_req_read  output  1  line fill request
l1_mmu_req_write  output  1  line writeback request
l1_mmu_req_addr  output  32  line-aligned address, low log2(LINE_BITS/8) bits zero
l1_mmu_write_data  output  LINE_BITS  victim line data
mmu_l1_read_done  input  1  fill data valid, single-cycle pulse
mmu_l1_write_done  input  1  writeback accepted, single-cycle pulse
mmu_l1_read_data  input  LINE_BITS  fill line

Behaviour:
Address split:
- OFF = log2(LINE_BITS/8); IDX = log2(SETS).
- Offset = addr[OFF-1:0]; index = addr[OFF+IDX-1:OFF]; tag = remaining upper bits.

Lookup and stall:
- Lookup is combinational across all ways. Hit = valid and tag match.
- stall = (l1_read | l1_write) & (~hit | state != IDLE).
- Read hit: l1_data_o = word addr[OFF-1:2] of the hit line, same cycle. It is 0 when no request or on a miss.
- Write hit: merged into the line at the next posedge and the line's dirty bit is set.
  - Half: lane chosen by addr[1].
  - Byte: lane chosen by addr[1:0].
  - Word: ignores addr[1:0].
- Read and write asserted together: handled as a write.

FSM states IDLE, WB, FILL:
- IDLE, request misses:
  - Victim = lowest-index invalid way. If none, the way named by the replacement state.
  - Victim valid and dirty: go to WB. Otherwise go to FILL.
- WB:
  - l1_mmu_req_write=1; l1_mmu_req_addr = {victim tag, index, 0}; l1_mmu_write_data = victim line.
  - All three held until mmu_l1_write_done is sampled high, then go to FILL.
- FILL:
  - l1_mmu_req_read=1; l1_mmu_req_addr = {request tag, index, 0}.
  - When mmu_l1_read_done is sampled high: write mmu_l1_read_data into the victim way; set valid=1, dirty=0, tag updated; go to IDLE.
  - The held request then hits in IDLE, so miss latency = MMU latency + 1 cycle.
- Request outputs drop in the cycle after done is sampled. Done arriving for the wrong type, or outside WB/FILL, is ignored.

Replacement state:
- WAYS=1: none.
- WAYS=2: one bit per set, pointing at the least-recently-used way.
- WAYS=4: 3-bit tree-PLRU per set.
- Updated on every hit access (read or write) and on every fill, to mark the touched way most-recent.

Reset:
- Reset (asynchronous) clears all valid, dirty and replacement bits and forces IDLE.
- All outputs go to 0 immediately.
- Reset mid-WB/FILL abandons the transfer; no partial line is installed.

Optional Feature:
Macro L1_PERF_CNT_EN.
- Defined:
  - Adds outputs l1_hit_cnt[31:0], l1_miss_cnt[31:0] and l1_wb_cnt[31:0].
  - Hit counter increments once per accepted request that hits in IDLE on first presentation. A retried hit after a fill is not counted.
  - Miss counter increments on each IDLE→WB/FILL transition.
  - Writeback counter increments on each WB→FILL transition.
  - All counters wrap at 2^32 and reset to 0.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
Defaults used (WAYS=2, SETS=64, LINE_BITS=256): OFF=5, index=addr[10:5].
1. Cold read 0x0000000C → stall=1, l1_mmu_req_read=1, l1_mmu_req_addr=0x00000000, no req_write. After done with word3=0x11223344 → l1_data_o=0x11223344, stall=0.
2. Read 0x00000000 then 0x00000800 (same set, different tags) → two fills. Re-reading both → stall=0, no MMU requests.
3. Fill 0x000 and 0x800; write word 0xAAAABBBB to 0x00C; read 0x800; read 0x1000:
   - Victim is the 0x000 line, so req_write addr=0x00000000 with bits[127:96]=0xAAAABBBB.
   - After write_done → req_read addr=0x00001000.
4. Write half 0xABCD to 0x0000000E, then byte 0x5A to 0x0000000D → read 0x0000000C returns 0xABCD5A44, given a fill word of 0x11223344.
5. Hold a miss; assert rst_n=0 during FILL → l1_mmu_req_read falls immediately. After release, reading the same address misses and requests again.
6. With L1_PERF_CNT_EN defined, run scenario 3 → l1_hit_cnt=2, l1_miss_cnt=3, l1_wb_cnt=1.

Source files
------------

// File: rtl/l1cache_assoc.sv
// l1cache_assoc: parametrised set-associative write-back, write-allocate L1 data cache (LRU / tree-PLRU).
// Defining L1_PERF_CNT_EN adds the hit, miss and writeback counter outputs.
module l1cache_assoc #(
    parameter int WAYS = 2,
    parameter int SETS = 64,
    parameter int LINE_BITS = 256
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 l1_read,
    input  logic                 l1_write,
    input  logic [31:0]          l1_addr,
    input  logic [1:0]           l1_write_type,
    input  logic [31:0]          l1_write_data,
    output logic [31:0]          l1_data_o,
    output logic                 stall,
    output logic                 l1_mmu_req_read,
    output logic                 l1_mmu_req_write,
    output logic [31:0]          l1_mmu_req_addr,
    output logic [LINE_BITS-1:0] l1_mmu_write_data,
    input  logic                 mmu_l1_read_done,
    input  logic                 mmu_l1_write_done,
    input  logic [LINE_BITS-1:0] mmu_l1_read_data
`ifdef L1_PERF_CNT_EN
    ,
    output logic [31:0]          l1_hit_cnt,
    output logic [31:0]          l1_miss_cnt,
    output logic [31:0]          l1_wb_cnt
`endif
);
    localparam int OFF = $clog2(LINE_BITS / 8);
    localparam int IDX = $clog2(SETS);
    localparam int TW = 32 - OFF - IDX;
    localparam int WW = WAYS > 1 ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, WB, FILL} state_t;
    state_t state;

    logic [LINE_BITS-1:0] data_q [WAYS][SETS];
    logic [TW-1:0] tag_q [WAYS][SETS];
    logic valid_q [WAYS][SETS];
    logic dirty_q [WAYS][SETS];
    logic [2:0] repl_q [SETS];
    logic [WW-1:0] vic_q;
    logic mmu_rd_q, mmu_wr_q;
    logic [31:0] mmu_addr_q;

    logic req, hit, has_free, idle_hit;
    logic [IDX-1:0] idx;
    logic [TW-1:0] tag;
    logic [OFF-3:0] woff;
    logic [WW-1:0] hit_way, free_way, vic;
    logic [1:0] plru_way;
    logic [2:0] r;
    logic [LINE_BITS-1:0] hit_line;
    logic [31:0] hit_word, wr_word;

    assign req = l1_read | l1_write;
    assign idx = l1_addr[OFF+IDX-1:OFF];
    assign tag = l1_addr[31:OFF+IDX];
    assign woff = l1_addr[OFF-1:2];

    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        has_free = 1'b0;
        free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
                hit = 1'b1;
                hit_way = WW'(w);
            end
            if (!valid_q[w][idx]) begin
                has_free = 1'b1;
                free_way = WW'(w);
            end
        end
    end

    // Tree bits: [0] root, [1] pair 0/1, [2] pair 2/3; each points at the less recent side.
    assign r = repl_q[idx];
    assign plru_way = WAYS == 4 ? {r[0], r[0] ? r[2] : r[1]} : WAYS == 2 ? {1'b0, r[0]} : 2'b00;
    assign vic = has_free ? free_way : WW'(plru_way);

    function automatic logic [2:0] touch(input logic [2:0] old, input logic [1:0] w);
        return WAYS == 4 ? (w[1] ? {~w[0], old[1], 1'b0} : {old[2], ~w[0], 1'b1}) : {2'b00, ~w[0]};
    endfunction

    assign hit_line = data_q[hit_way][idx];
    assign hit_word = hit_line[{woff, 5'd0} +: 32];

    always_comb begin
        wr_word = l1_write_data;
        if (l1_write_type == 2'b01) begin
            wr_word = hit_word;
            wr_word[{l1_addr[1], 4'd0} +: 16] = l1_write_data[15:0];
        end else if (l1_write_type == 2'b10) begin
            wr_word = hit_word;
            wr_word[{l1_addr[1:0], 3'd0} +: 8] = l1_write_data[7:0];
        end
    end

    assign idle_hit = rst_n && req && hit && state == IDLE;
    assign stall = rst_n && req && (!hit || state != IDLE);
    assign l1_data_o = (rst_n && req && hit) ? hit_word : '0;
    assign l1_mmu_req_read = mmu_rd_q;
    assign l1_mmu_req_write = mmu_wr_q;
    assign l1_mmu_req_addr = mmu_addr_q;
    assign l1_mmu_write_data = mmu_wr_q ? data_q[vic_q][idx] : '0;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mmu_rd_q <= 1'b0;
            mmu_wr_q <= 1'b0;
            mmu_addr_q <= '0;
            vic_q <= '0;
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                end
            for (int s = 0; s < SETS; s++) repl_q[s] <= '0;
        end else begin
            case (state)
                IDLE: if (idle_hit) begin
                    repl_q[idx] <= touch(repl_q[idx], 2'(hit_way));
                    if (l1_write) dirty_q[hit_way][idx] <= 1'b1;
                end else if (req && !hit) begin
                    vic_q <= vic;
                    if (valid_q[vic][idx] && dirty_q[vic][idx]) begin
                        state <= WB;
                        mmu_wr_q <= 1'b1;
                        mmu_addr_q <= {tag_q[vic][idx], idx, {OFF{1'b0}}};
                    end else begin
                        state <= FILL;
                        mmu_rd_q <= 1'b1;
                        mmu_addr_q <= {tag, idx, {OFF{1'b0}}};
                    end
                end
                WB: if (mmu_l1_write_done) begin
                    state <= FILL;
                    mmu_wr_q <= 1'b0;
                    mmu_rd_q <= 1'b1;
                    mmu_addr_q <= {tag, idx, {OFF{1'b0}}};
                end
                FILL: if (mmu_l1_read_done) begin
                    state <= IDLE;
                    mmu_rd_q <= 1'b0;
                    mmu_addr_q <= '0;
                    valid_q[vic_q][idx] <= 1'b1;
                    dirty_q[vic_q][idx] <= 1'b0;
                    repl_q[idx] <= touch(repl_q[idx], 2'(vic_q));
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line storage needs no reset: valid bits gate every use.
    always_ff @(posedge sys_clk) begin
        if (idle_hit && l1_write) data_q[hit_way][idx][{woff, 5'd0} +: 32] <= wr_word;
        if (state == FILL && mmu_l1_read_done) begin
            data_q[vic_q][idx] <= mmu_l1_read_data;
            tag_q[vic_q][idx] <= tag;
        end
    end

`ifdef L1_PERF_CNT_EN
    logic retry_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_q <= 1'b0;
            l1_hit_cnt <= '0;
            l1_miss_cnt <= '0;
            l1_wb_cnt <= '0;
        end else begin
            if (idle_hit) retry_q <= 1'b0;
            else if (state == FILL && mmu_l1_read_done) retry_q <= 1'b1;
            if (idle_hit && !retry_q) l1_hit_cnt <= l1_hit_cnt + 32'd1;
            if (state == IDLE && req && !hit) l1_miss_cnt <= l1_miss_cnt + 32'd1;
            if (state == WB && mmu_l1_write_done) l1_wb_cnt <= l1_wb_cnt + 32'd1;
        end
    end
`else
`endif
endmodule
